// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin two-requester arbiter driving the muxA select and a registered valid/ready output
module mux_arbiter #(
    parameter int WIDTH = 16,
    parameter bit FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in2,
    output logic             gnt2,
    output logic             sel,
    output logic [WIDTH-1:0] outA,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state;
    logic       last;       // 0: requester 1 won last grant, 1: requester 2
    logic       elig1;
    logic       elig2;
    logic       have_win;
    logic       win2;

    // A requester seeing its grant this cycle is masked so a late req drop cannot double-grant.
    always_comb begin
        elig1    = req1 & ~gnt1;
        elig2    = req2 & ~gnt2;
        have_win = elig1 | elig2;
        win2     = elig2 & (~elig1 | ~last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            outA      <= '0;
            out_valid <= 1'b0;
            gnt1      <= 1'b0;
            gnt2      <= 1'b0;
            last      <= ~FIRST;
        end else begin
            gnt1 <= 1'b0;
            gnt2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (have_win) begin
                        sel       <= win2;
                        outA      <= win2 ? in2 : in1;
                        out_valid <= 1'b1;
                        gnt1      <= ~win2;
                        gnt2      <= win2;
                        last      <= win2;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (have_win) begin
                            sel       <= win2;
                            outA      <= win2 ? in2 : in1;
                            out_valid <= 1'b1;
                            gnt1      <= ~win2;
                            gnt2      <= win2;
                            last      <= win2;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed vector bench for mux_arbiter
module tb_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req1;
    logic [15:0] in1;
    logic        gnt1;
    logic        req2;
    logic [15:0] in2;
    logic        gnt2;
    logic        sel;
    logic [15:0] outA;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int failures;

    typedef struct {
        logic        rst_n;
        logic        req1;
        logic [15:0] in1;
        logic        req2;
        logic [15:0] in2;
        logic        rdy;
        logic        e_valid;
        logic        e_sel;
        logic [15:0] e_outa;
        logic        e_g1;
        logic        e_g2;
    } vec_t;

    vec_t vecs[$];

    mux_arbiter #(.WIDTH(16), .FIRST(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req1      (req1),
        .in1       (in1),
        .gnt1      (gnt1),
        .req2      (req2),
        .in2       (in2),
        .gnt2      (gnt2),
        .sel       (sel),
        .outA      (outA),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic q1, input logic [15:0] d1,
                                input logic q2, input logic [15:0] d2, input logic rd,
                                input logic ev, input logic es, input logic [15:0] eo,
                                input logic eg1, input logic eg2);
        vec_t v;
        v.rst_n = r;  v.req1 = q1; v.in1 = d1; v.req2 = q2; v.in2 = d2; v.rdy = rd;
        v.e_valid = ev; v.e_sel = es; v.e_outa = eo; v.e_g1 = eg1; v.e_g2 = eg2;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic r, input logic q1, input logic [15:0] d1,
                        input logic q2, input logic [15:0] d2, input logic rd);
        rst_n = r; req1 = q1; in1 = d1; req2 = q2; in2 = d2; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic es,
                         input logic [15:0] eo, input logic eg1, input logic eg2);
        checks++;
        if (out_valid !== ev || sel !== es || outA !== eo || gnt1 !== eg1 || gnt2 !== eg2) begin
            failures++;
            $display("FAIL %s: got valid=%b sel=%b outA=%h gnt1=%b gnt2=%b, expected valid=%b sel=%b outA=%h gnt1=%b gnt2=%b",
                     name, out_valid, sel, outA, gnt1, gnt2, ev, es, eo, eg1, eg2);
        end
        checks++;
        if (gnt1 === 1'b1 && gnt2 === 1'b1) begin
            failures++;
            $display("FAIL %s_excl: got gnt1=%b gnt2=%b, expected not both high", name, gnt1, gnt2);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;

        // reset held with both requests active
        add(0, 1, 16'h0001, 1, 16'h0002, 0,   0, 0, 16'h0000, 0, 0);
        add(0, 1, 16'h0001, 1, 16'h0002, 0,   0, 0, 16'h0000, 0, 0);
        // single request, then requester drops after its grant
        add(1, 1, 16'h0001, 0, 16'h0000, 1,   1, 0, 16'h0001, 1, 0);
        add(1, 0, 16'h0001, 0, 16'h0000, 1,   0, 0, 16'h0001, 0, 0);
        // reset restores pointer before contention
        add(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
        // contention at full throughput
        add(1, 1, 16'h0010, 1, 16'h0011, 1,   1, 0, 16'h0010, 1, 0);
        add(1, 1, 16'h0010, 1, 16'h0011, 1,   1, 1, 16'h0011, 0, 1);
        add(1, 1, 16'h0010, 1, 16'h0011, 1,   1, 0, 16'h0010, 1, 0);
        add(1, 1, 16'h0010, 1, 16'h0011, 1,   1, 1, 16'h0011, 0, 1);
        add(1, 1, 16'h0010, 1, 16'h0011, 1,   1, 0, 16'h0010, 1, 0);
        // backpressure with req2 pending
        for (int i = 0; i < 5; i++)
            add(1, 0, 16'h0010, 1, 16'h0011, 0,   1, 0, 16'h0010, 0, 0);
        add(1, 0, 16'h0010, 1, 16'h0011, 1,   1, 1, 16'h0011, 0, 1);
        add(1, 0, 16'h0010, 0, 16'h0011, 1,   0, 1, 16'h0011, 0, 0);
        // late drop of req1
        add(1, 1, 16'h0005, 0, 16'h0000, 1,   1, 0, 16'h0005, 1, 0);
        add(1, 1, 16'h0005, 0, 16'h0000, 1,   0, 0, 16'h0005, 0, 0);
        add(1, 0, 16'h0005, 0, 16'h0000, 1,   0, 0, 16'h0005, 0, 0);
        // reset mid-HOLD after req1 won, pointer must revert so req1 wins again
        add(1, 1, 16'h0022, 0, 16'h0000, 0,   1, 0, 16'h0022, 1, 0);
        add(1, 0, 16'h0022, 0, 16'h0000, 0,   1, 0, 16'h0022, 0, 0);
        add(0, 0, 16'h0022, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
        add(1, 1, 16'h0033, 1, 16'h0044, 0,   1, 0, 16'h0033, 1, 0);
        add(1, 0, 16'h0033, 1, 16'h0044, 0,   1, 0, 16'h0033, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req1, vecs[i].in1, vecs[i].req2, vecs[i].in2, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sel, vecs[i].e_outa,
                  vecs[i].e_g1, vecs[i].e_g2);
        end

        // withdrawal: req2 drops before its grant, then the held word is taken
        step(1, 0, 16'h0033, 0, 16'h0044, 1);
        check("withdraw_take", 0, 0, 16'h0033, 0, 0);
        step(1, 0, 16'h0033, 0, 16'h0044, 1);
        check("withdraw_idle", 0, 0, 16'h0033, 0, 0);

        // out_ready in IDLE is ignored; next lone req2 grant holds while not ready
        step(1, 0, 16'h0000, 1, 16'h00aa, 0);
        check("idle_req2", 1, 1, 16'h00aa, 0, 1);
        step(1, 0, 16'h0000, 0, 16'h00aa, 0);
        check("hold_req2", 1, 1, 16'h00aa, 0, 0);
        step(1, 0, 16'h0000, 0, 16'h00aa, 1);
        check("drain_req2", 0, 1, 16'h00aa, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
